// File: rtl/sin_meas.sv
// sin_meas: hysteretic rising-crossing detector for a real-valued sine.
// Reports period, amplitude and offset once per completed cycle.
module sin_meas #(
  parameter real THRESH     = 0.0,
  parameter real HYST       = 0.05,
  parameter int  CNT_W      = 16,
  parameter int  MAX_PERIOD = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  real              in_real,
  output logic [CNT_W-1:0] period_cyc,
  output real              amp_out,
  output real              ofs_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             no_signal
);

  if (MAX_PERIOD >= (1 << CNT_W)) begin : g_bad_max
    $fatal(1, "sin_meas: MAX_PERIOD must be below 2**CNT_W");
  end

  typedef enum logic [2:0] {
    IDLE,
    SEEK_LOW,
    SEEK_HIGH,
    MEAS_LOW,
    MEAS_HIGH
  } state_t;

  localparam real LO_TH = THRESH - HYST;
  localparam real HI_TH = THRESH + HYST;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] per_d;
  real              min_v, max_v, min_d, max_d;
  real              lo_n, hi_n, amp_d, ofs_d;
  logic             valid_d, locked_d, nosig_d;
  logic             ev_low, ev_high, timeout;

  always_comb begin
    ev_low   = in_real < LO_TH;
    ev_high  = in_real >= HI_TH;
    lo_n     = (in_real < min_v) ? in_real : min_v;
    hi_n     = (in_real > max_v) ? in_real : max_v;
    timeout  = (state != IDLE) && (cnt == MAX_CNT);
    state_d  = state;
    cnt_d    = cnt;
    min_d    = min_v;
    max_d    = max_v;
    per_d    = period_cyc;
    amp_d    = amp_out;
    ofs_d    = ofs_out;
    valid_d  = 1'b0;
    locked_d = locked;
    nosig_d  = no_signal;
    if (!en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (timeout) begin
      // a rising event landing on this cycle is deliberately dropped
      state_d  = SEEK_LOW;
      cnt_d    = '0;
      locked_d = 1'b0;
      nosig_d  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = SEEK_LOW;
          cnt_d   = ONE;
        end
        SEEK_LOW: begin
          cnt_d = cnt + ONE;
          if (ev_low) state_d = SEEK_HIGH;
        end
        SEEK_HIGH: begin
          cnt_d = cnt + ONE;
          if (ev_high) begin
            state_d = MEAS_LOW;
            cnt_d   = ONE;
            min_d   = in_real;
            max_d   = in_real;
          end
        end
        MEAS_LOW: begin
          cnt_d = cnt + ONE;
          min_d = lo_n;
          max_d = hi_n;
          if (ev_low) state_d = MEAS_HIGH;
        end
        MEAS_HIGH: begin
          cnt_d = cnt + ONE;
          min_d = lo_n;
          max_d = hi_n;
          if (ev_high) begin
            per_d    = cnt;
            amp_d    = (hi_n - lo_n) / 2.0;
            ofs_d    = (hi_n + lo_n) / 2.0;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            nosig_d  = 1'b0;
            cnt_d    = ONE;
            min_d    = in_real;
            max_d    = in_real;
            state_d  = MEAS_LOW;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      min_v      <= 0.0;
      max_v      <= 0.0;
      period_cyc <= '0;
      amp_out    <= 0.0;
      ofs_out    <= 0.0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      min_v      <= min_d;
      max_v      <= max_d;
      period_cyc <= per_d;
      amp_out    <= amp_d;
      ofs_out    <= ofs_d;
      meas_valid <= valid_d;
      locked     <= locked_d;
      no_signal  <= nosig_d;
    end
  end

endmodule

// File: tb/tb_sin_meas.sv
// tb_sin_meas: directed bench for sin_meas with a Schmitt-trigger
// and timestamp reference model checked every cycle.
module tb_sin_meas;

  localparam int  CNT_W = 16;
  localparam int  MAXP  = 10000;
  localparam real TH    = 0.3;
  localparam real HY    = 0.05;
  localparam real PI    = 3.14159265358979;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  real              in_r = 0.3;
  logic [CNT_W-1:0] period_cyc;
  real              amp_out, ofs_out;
  logic             meas_valid, locked, no_signal;

  sin_meas #(
    .THRESH(TH), .HYST(HY), .CNT_W(CNT_W), .MAX_PERIOD(MAXP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_real(in_r),
    .period_cyc(period_cyc), .amp_out(amp_out), .ofs_out(ofs_out),
    .meas_valid(meas_valid), .locked(locked), .no_signal(no_signal)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;
  int   vcount = 0;
  int   first_v = -1;
  int   rise_cyc = -1;
  logic prev_ns = 1'b0;
  int   ph = 0;

  // reference model: Schmitt trigger state plus event timestamps
  bit  act, have_ref;
  int  sch = -1;
  int  ref_c;
  real q[$];
  int  m_per;
  real m_amp, m_ofs;
  bit  m_v, m_l, m_ns;

  function automatic bit close(real a, real b, real tol);
    return (a - b < tol) && (b - a < tol);
  endfunction

  task automatic check(bit ok, string nm, string got, string want);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, want %s", nm, got, want);
  endtask

  task automatic model_step();
    bit  lo, hi, evt;
    real mn, mx;
    m_v = 1'b0;
    if (rst) begin
      act = 0; have_ref = 0; sch = -1; q.delete();
      m_per = 0; m_amp = 0.0; m_ofs = 0.0; m_l = 0; m_ns = 0;
    end else if (!en) begin
      act = 0; m_l = 0;
    end else if (!act) begin
      act = 1; have_ref = 0; sch = -1; ref_c = cyc;
    end else if (cyc - ref_c == MAXP) begin
      m_ns = 1; m_l = 0; have_ref = 0; sch = -1; ref_c = cyc + 1;
    end else begin
      lo  = in_r < TH - HY;
      hi  = in_r >= TH + HY;
      evt = hi && (sch == 0);
      if (lo) sch = 0;
      if (have_ref) q.push_back(in_r);
      if (evt) begin
        if (have_ref) begin
          mn = q[0];
          mx = q[0];
          foreach (q[i]) begin
            if (q[i] < mn) mn = q[i];
            if (q[i] > mx) mx = q[i];
          end
          m_per = cyc - ref_c;
          m_amp = (mx - mn) / 2.0;
          m_ofs = (mx + mn) / 2.0;
          m_v = 1; m_l = 1; m_ns = 0;
        end
        ref_c = cyc;
        q.delete();
        q.push_back(in_r);
        have_ref = 1;
        sch = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step();
    #1;
    check(int'(period_cyc) == m_per && close(amp_out, m_amp, 1e-9) &&
          close(ofs_out, m_ofs, 1e-9) && meas_valid == m_v &&
          locked == m_l && no_signal == m_ns,
          $sformatf("cycle_cmp@%0d", cyc),
          $sformatf("per=%0d amp=%f ofs=%f v=%b l=%b ns=%b",
                    period_cyc, amp_out, ofs_out, meas_valid, locked, no_signal),
          $sformatf("per=%0d amp=%f ofs=%f v=%b l=%b ns=%b",
                    m_per, m_amp, m_ofs, m_v, m_l, m_ns));
    if (meas_valid) begin
      vcount++;
      if (first_v < 0) first_v = cyc;
    end
    if (no_signal && !prev_ns) rise_cyc = cyc;
    prev_ns = no_signal;
  end

  task automatic drive(real v);
    @(negedge clk);
    in_r = v;
  endtask

  task automatic sine(int n, real a, real o, int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      drive(o + a * $sin(2.0 * PI * ph / n));
      ph++;
    end
  endtask

  task automatic wait_valid(int n, real a, real o, int budget, string nm);
    int v0;
    int k;
    v0 = vcount;
    k = 0;
    while (vcount == v0 && k < budget) begin
      sine(n, a, o, 1);
      k++;
    end
    check(vcount != v0, nm, "timeout", "meas_valid");
  endtask

  task automatic check_reset(string nm);
    check(period_cyc == '0, {nm, "_per"}, $sformatf("%0d", period_cyc), "0");
    check(amp_out == 0.0, {nm, "_amp"}, $sformatf("%f", amp_out), "0.0");
    check(ofs_out == 0.0, {nm, "_ofs"}, $sformatf("%f", ofs_out), "0.0");
    check(meas_valid == 1'b0, {nm, "_valid"}, $sformatf("%b", meas_valid), "0");
    check(locked == 1'b0, {nm, "_locked"}, $sformatf("%b", locked), "0");
    check(no_signal == 1'b0, {nm, "_nosig"}, $sformatf("%b", no_signal), "0");
  endtask

  task automatic check_meas(string nm, int p, real a, real o);
    check(int'(period_cyc) >= p - 1 && int'(period_cyc) <= p + 1,
          {nm, "_per"}, $sformatf("%0d", period_cyc), $sformatf("%0d+-1", p));
    check(close(amp_out, a, 0.01), {nm, "_amp"},
          $sformatf("%f", amp_out), $sformatf("%f+-0.01", a));
    check(close(ofs_out, o, 0.01), {nm, "_ofs"},
          $sformatf("%f", ofs_out), $sformatf("%f+-0.01", o));
  endtask

  initial begin
    int e0, v0, r0;

    repeat (3) drive(TH);
    check_reset("reset");
    rst = 1'b0;

    // basic 1 us sine, amplitude 1
    en = 1'b1;
    e0 = cyc + 1;
    first_v = -1;
    v0 = vcount;
    ph = 0;
    sine(100, 1.0, 0.0, 400);
    check(first_v - e0 == 107, "first_valid_lat",
          $sformatf("%0d", first_v - e0), "107");
    check(vcount - v0 == 3, "basic_pulses", $sformatf("%0d", vcount - v0), "3");
    check_meas("basic", 100, 1.0, 0.0);
    check(locked == 1'b1, "basic_locked", $sformatf("%b", locked), "1");

    // offset sine around the threshold
    ph = 0;
    sine(200, 0.5, 0.3, 800);
    check_meas("offset", 200, 0.5, 0.3);

    // en dropped mid-period
    ph = 0;
    wait_valid(100, 1.0, 0.0, 300, "en_pre_valid1");
    wait_valid(100, 1.0, 0.0, 200, "en_pre_valid2");
    sine(100, 1.0, 0.0, 40);
    en = 1'b0;
    v0 = vcount;
    sine(100, 1.0, 0.0, 5);
    check(locked == 1'b0, "en_drop_locked", $sformatf("%b", locked), "0");
    check_meas("en_drop_hold", 100, 1.0, 0.0);
    en = 1'b1;
    r0 = cyc + 1;
    first_v = -1;
    wait_valid(100, 1.0, 0.0, 400, "reenable_valid");
    check(first_v - r0 > 100 && first_v - r0 < 300, "reenable_lat",
          $sformatf("%0d", first_v - r0), "101..299");
    check(v0 + 1 == vcount, "reenable_one_pulse",
          $sformatf("%0d", vcount - v0), "1");

    // rst mid-period
    sine(100, 1.0, 0.0, 30);
    rst = 1'b1;
    en = 1'b0;
    sine(100, 1.0, 0.0, 1);
    check_reset("mid_rst");
    rst = 1'b0;
    drive(TH);

    // in-band dither only
    en = 1'b1;
    e0 = cyc + 1;
    rise_cyc = -1;
    v0 = vcount;
    for (int i = 0; i < MAXP + 5; i++) drive((i % 2 == 0) ? TH + 0.03 : TH - 0.03);
    check(rise_cyc - e0 == MAXP, "hyst_timeout_at",
          $sformatf("%0d", rise_cyc - e0), $sformatf("%0d", MAXP));
    check(vcount == v0, "hyst_no_valid", $sformatf("%0d", vcount - v0), "0");
    check(locked == 1'b0, "hyst_locked", $sformatf("%b", locked), "0");

    // timeout and recovery
    rst = 1'b1;
    drive(TH);
    rst = 1'b0;
    ph = 0;
    wait_valid(100, 1.0, 0.0, 400, "to_lock1");
    wait_valid(100, 1.0, 0.0, 200, "to_lock2");
    check(locked == 1'b1, "to_locked", $sformatf("%b", locked), "1");
    repeat (MAXP + 10) drive(TH);
    check(no_signal == 1'b1, "to_nosig", $sformatf("%b", no_signal), "1");
    check(locked == 1'b0, "to_unlocked", $sformatf("%b", locked), "0");
    check_meas("to_hold", 100, 1.0, 0.0);
    ph = 0;
    wait_valid(100, 1.0, 0.0, 400, "to_recover");
    check(no_signal == 1'b0, "to_nosig_clr", $sformatf("%b", no_signal), "0");
    check_meas("to_recover", 100, 1.0, 0.0);

    // frequency sweep
    ph = 0;
    sine(20, 1.0, 0.0, 60);
    check_meas("sweep_200ns", 20, 1.0, 0.0);
    ph = 0;
    sine(500, 1.0, 0.0, 1500);
    check_meas("sweep_5us", 500, 1.0, 0.0);
    ph = 0;
    sine(9000, 1.0, 0.0, 27000);
    check_meas("sweep_90us", 9000, 1.0, 0.0);
    check(no_signal == 1'b0 && locked == 1'b1, "sweep_90us_flags",
          $sformatf("ns=%b l=%b", no_signal, locked), "ns=0 l=1");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
